// File: rtl/reset_seq.sv
// Reset sequencer: synchronised POR, staggered per-channel release, SW reset.
// Optional watchdog enabled by defining RESET_SEQ_WDT_EN.
module reset_seq #(
  parameter int NUM_RESETS     = 3,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 4,
  parameter int STAGGER_CYCLES = 3,
  parameter int WDT_CYCLES     = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  sw_rst_req_i,
  input  logic                  wdt_kick_i,
  output logic [NUM_RESETS-1:0] rst_no,
  output logic                  busy_o,
  output logic [1:0]            cause_o
);
  localparam int MAX_HS =
    (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int MAX_C =
    (MAX_HS > WDT_CYCLES) ? MAX_HS : WDT_CYCLES;
  localparam int CW = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

  typedef enum logic [1:0] {
    S_RESET,
    S_HOLD,
    S_REL,
    S_RUN
  } state_t;

  state_t                r_state;
  state_t                w_state_nx;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_nx;
  logic [CW-1:0]         w_cnt_inc;
  logic [NUM_RESETS-1:0] r_rst_n;
  logic [NUM_RESETS-1:0] w_rst_n_nx;
  logic [NUM_RESETS-1:0] w_rel;
  logic [1:0]            r_cause;
  logic [1:0]            w_cause_nx;
  logic                  r_busy;
  logic                  w_sync;
  logic                  w_hold_done;
  logic                  w_stag_done;
  logic                  w_kick;
  logic                  w_wdt_fire;
  logic                  w_trig;

`ifdef RESET_SEQ_WDT_EN
  localparam logic [CW-1:0] WDT_LAST = CW'(WDT_CYCLES - 1);
  assign w_kick     = wdt_kick_i;
  assign w_wdt_fire = (r_state == S_RUN) && !wdt_kick_i &&
                      (r_cnt == WDT_LAST);
`else
  logic w_unused_kick;
  assign w_unused_kick = wdt_kick_i;
  assign w_kick        = 1'b0;
  assign w_wdt_fire    = 1'b0;
`endif

  assign w_sync      = r_sync[SYNC_STAGES-1];
  assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + CNT_ONE;
  assign w_hold_done = (r_cnt >= HOLD_LAST);
  assign w_stag_done = (r_cnt == STAG_LAST);
  assign w_rel       = NUM_RESETS'({r_rst_n, 1'b1});
  assign w_trig      = (r_state != S_RESET) &&
                       (sw_rst_req_i || w_wdt_fire);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_sync <= '0;
    else         r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_RESET;
    else         r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_RESET: if (w_sync) w_state_nx = S_HOLD;
      S_HOLD:
        if (w_hold_done)
          w_state_nx = (&w_rel) ? S_RUN : S_REL;
      S_REL:
        if (w_stag_done && (&w_rel))
          w_state_nx = S_RUN;
      default: w_state_nx = r_state;
    endcase
    if (w_trig) w_state_nx = S_HOLD;
  end

  // The sync-exit edge counts as the first hold cycle, so the first
  // release lands on edge SYNC_STAGES + HOLD_CYCLES.
  always_comb begin
    w_cnt_nx   = r_cnt;
    w_rst_n_nx = r_rst_n;
    w_cause_nx = r_cause;
    unique case (r_state)
      S_RESET: w_cnt_nx = w_sync ? CNT_ONE : '0;
      S_HOLD: begin
        if (w_hold_done) begin
          w_rst_n_nx = w_rel;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
      end
      S_REL: begin
        if (w_stag_done) begin
          w_rst_n_nx = w_rel;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
      end
      default: w_cnt_nx = w_kick ? '0 : w_cnt_inc;
    endcase
    if (w_trig) begin
      w_rst_n_nx = '0;
      w_cnt_nx   = '0;
      w_cause_nx = w_wdt_fire ? CAUSE_WDT : CAUSE_SW;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt   <= '0;
      r_rst_n <= '0;
      r_busy  <= 1'b1;
      r_cause <= CAUSE_POR;
    end else begin
      r_cnt   <= w_cnt_nx;
      r_rst_n <= w_rst_n_nx;
      r_busy  <= ~&w_rst_n_nx;
      r_cause <= w_cause_nx;
    end
  end

  assign rst_no  = r_rst_n;
  assign busy_o  = r_busy;
  assign cause_o = r_cause;

endmodule

// File: tb/tb_reset_seq.sv
// Bench for reset_seq: edge-count model of the release schedule,
// checked every cycle, plus literal checkpoints.
module tb_reset_seq;
  localparam int N  = 3;
  localparam int SY = 2;
  localparam int H  = 4;
  localparam int ST = 3;
`ifdef RESET_SEQ_WDT_EN
  localparam int W  = 16;
`endif

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         sw    = 1'b0;
  logic         kick  = 1'b0;
  logic [N-1:0] rst_no;
  logic         busy_o;
  logic [1:0]   cause_o;

  reset_seq dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .sw_rst_req_i(sw),
    .wdt_kick_i  (kick),
    .rst_no      (rst_no),
    .busy_o      (busy_o),
    .cause_o     (cause_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // n: edges since rst_ni high; base: edge the schedule is anchored to
  int         n       = 0;
  int         base    = SY;
  int         wcnt    = 0;
  logic [1:0] m_cause = 2'b00;

  function automatic logic [N-1:0] m_rst();
    logic [N-1:0] v;
    for (int k = 0; k < N; k++)
      v[k] = (n >= base + H + k * ST);
    return v;
  endfunction

  function automatic logic m_busy();
    return m_rst() != {N{1'b1}};
  endfunction

  function automatic bit in_run();
    return n >= base + H + (N - 1) * ST;
  endfunction

  function automatic bit wdt_fire();
`ifdef RESET_SEQ_WDT_EN
    return in_run() && !kick && (wcnt + 1 == W);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n       <= 0;
      base    <= SY;
      m_cause <= 2'b00;
      wcnt    <= 0;
    end else begin
      n <= n + 1;
      if (wdt_fire()) begin
        base    <= n + 1;
        m_cause <= 2'b10;
        wcnt    <= 0;
      end else if (sw && n > SY) begin
        base    <= n + 1;
        m_cause <= 2'b01;
        wcnt    <= 0;
      end else if (in_run()) begin
        wcnt <= kick ? 0 : wcnt + 1;
      end else begin
        wcnt <= 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      n_checks++;
      if (rst_no !== m_rst() || busy_o !== m_busy() ||
          cause_o !== m_cause) begin
        n_fail++;
        $display("FAIL cycle n=%0d rst_no=%b busy=%b cause=%b exp %b %b %b",
                 n, rst_no, busy_o, cause_o, m_rst(), m_busy(), m_cause);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_n(input int t);
    int g = 0;
    while (n < t && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (n != t) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_n n=%0d target=%0d", n, t);
    end
  endtask

  task automatic chk_rst(input string nm, input logic [N-1:0] exp);
    chk({nm, "_dut"}, 32'(rst_no), 32'(exp));
    chk({nm, "_mdl"}, 32'(m_rst()), 32'(exp));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk_rst("por_hold", 3'b000);
    chk("por_busy", 32'(busy_o), 32'd1);
    chk("por_cause", 32'(cause_o), 32'd0);
    rst_n = 1'b1;

    wait_n(5);  chk_rst("e5", 3'b000);
    wait_n(6);  chk_rst("e6", 3'b001);
    wait_n(9);  chk_rst("e9", 3'b011);
    chk("e9_busy", 32'(busy_o), 32'd1);
    wait_n(12); chk_rst("e12", 3'b111);
    chk("e12_busy", 32'(busy_o), 32'd0);
    chk("e12_cause", 32'(cause_o), 32'd0);

    wait_n(19); sw = 1'b1;
    wait_n(20); sw = 1'b0;
    chk_rst("sw20", 3'b000);
    chk("sw20_cause", 32'(cause_o), 32'd1);
    wait_n(23); chk_rst("sw23", 3'b000);
    wait_n(24); chk_rst("sw24", 3'b001);
    wait_n(27); chk_rst("sw27", 3'b011);
    wait_n(30); chk_rst("sw30", 3'b111);
    chk("sw30_busy", 32'(busy_o), 32'd0);

    wait_n(33); sw = 1'b1;
    wait_n(34); sw = 1'b0;
    wait_n(39); chk_rst("pre_pulse", 3'b001);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst", 32'(rst_no), 32'd0);
    chk("async_busy", 32'(busy_o), 32'd1);
    chk("async_cause", 32'(cause_o), 32'd0);
    #2 rst_n = 1'b1;

    wait_n(6);  chk_rst("por2_e6", 3'b001);
    wait_n(7);  sw = 1'b1;
    wait_n(8);  sw = 1'b0;
    chk_rst("rel_sw8", 3'b000);
    chk("rel_sw8_cause", 32'(cause_o), 32'd1);
    wait_n(11); chk_rst("rel_sw11", 3'b000);
    wait_n(12); chk_rst("rel_sw12", 3'b001);
    wait_n(15); chk_rst("rel_sw15", 3'b011);
    wait_n(18); chk_rst("rel_sw18", 3'b111);
    chk("rel_sw18_busy", 32'(busy_o), 32'd0);

`ifdef RESET_SEQ_WDT_EN
    wait_n(33); chk_rst("wdt33", 3'b111);
    wait_n(34); chk_rst("wdt34", 3'b000);
    chk("wdt34_cause", 32'(cause_o), 32'd2);
    wait_n(38); chk_rst("wdt38", 3'b001);
    wait_n(44); chk_rst("wdt44", 3'b111);
    for (int e = 45; e <= 244; e++) begin
      kick = (e % 10 == 4);
      wait_n(e);
    end
    kick = 1'b0;
    chk_rst("kicked", 3'b111);
    chk("kicked_cause", 32'(cause_o), 32'd2);
    wait_n(259); sw = 1'b1;
    wait_n(260); sw = 1'b0;
    chk_rst("both260", 3'b000);
    chk("both260_cause", 32'(cause_o), 32'd2);
    wait_n(264); chk_rst("both264", 3'b001);
    wait_n(270); chk_rst("both270", 3'b111);
    chk("both270_cause", 32'(cause_o), 32'd2);
`else
    for (int e = 19; e <= 218; e++) begin
      kick = (e % 7 == 0);
      wait_n(e);
    end
    kick = 1'b0;
    chk_rst("nowdt", 3'b111);
    chk("nowdt_cause", 32'(cause_o), 32'd1);
    chk("nowdt_busy", 32'(busy_o), 32'd0);
`endif

    @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
